// File: rtl/neuron_mac_lanes.sv
// Single neuron: LANES-wide MAC over stored weights, bias add,
// saturation and a selectable activation behind valid/ready handshakes.
module neuron_mac_lanes #(
  parameter int LAYER_NO   = 1,
  parameter int NEURON_NO  = 1,
  parameter int NUM_WEIGHT = 128,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ACT_MODE   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    cfg_layer_num,
  input  logic [7:0]                    cfg_neuron_num,
  input  logic                          weight_valid,
  input  logic [DATA_WIDTH-1:0]         weight_value,
  input  logic                          bias_valid,
  input  logic [DATA_WIDTH-1:0]         bias_value,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          busy,
  output logic                          sat_flag
);

  localparam int DW    = DATA_WIDTH;
  localparam int PW    = 2 * DW;
  localparam int ACC_W = PW + $clog2(NUM_WEIGHT) + 1;
  localparam int BEATS = (NUM_WEIGHT + LANES - 1) / LANES;
  localparam int AW    = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, ACT, OUT} state_t;

  state_t state, state_nxt;

  logic                    run;
  logic [AW-1:0]           waddr;
  logic signed [DW-1:0]    bias_q;
  logic [BW-1:0]           bcnt;
  logic [1:0]              dcnt;
  logic                    v1, v2;
  logic signed [ACC_W-1:0] acc;

  logic signed [DW-1:0]    mem    [NUM_WEIGHT];
  logic signed [DW-1:0]    w_q    [LANES];
  logic signed [DW-1:0]    x_q    [LANES];
  logic signed [PW-1:0]    prod_q [LANES];

  logic                    id_ok, w_we, b_we;
  logic                    beat_fire, last_beat;
  logic                    lane_ok  [LANES];
  logic [AW-1:0]           lane_idx [LANES];

  logic signed [ACC_W-1:0] psum, shifted, max_v, min_v;
  logic signed [DW-1:0]    sat_v, act_v;
  logic                    sat_hit;
  logic signed [DW+1:0]    hs, one_q;

  assign id_ok = (state == IDLE)
              && (cfg_layer_num == 8'(LAYER_NO))
              && (cfg_neuron_num == 8'(NEURON_NO));
  assign w_we  = weight_valid && id_ok;
  assign b_we  = bias_valid && id_ok;

  // Config writes win over a same-cycle beat in IDLE
  assign in_ready  = run && ((state == IDLE && !w_we && !b_we)
                          || state == ACCUM);
  assign beat_fire = in_valid && in_ready;
  assign last_beat = (bcnt == BW'(BEATS - 1));
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (beat_fire) state_nxt = last_beat ? DRAIN : ACCUM;
      ACCUM: if (beat_fire && last_beat) state_nxt = DRAIN;
      DRAIN: if (dcnt == 2'd2) state_nxt = BIAS;
      BIAS:  state_nxt = ACT;
      ACT:   state_nxt = OUT;
      OUT:   if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_ok[l]  = (int'(bcnt) * LANES + l) < NUM_WEIGHT;
      lane_idx[l] = AW'(int'(bcnt) * LANES + l);
    end
  end

  always_comb begin
    psum = '0;
    for (int l = 0; l < LANES; l++)
      psum = psum + ACC_W'(prod_q[l]);
  end

  always_comb begin
    shifted = acc >>> FRAC_WIDTH;
    max_v   = ACC_W'({(DW-1){1'b1}});
    min_v   = ~max_v;
    sat_hit = (shifted > max_v) || (shifted < min_v);
    if (shifted > max_v)      sat_v = max_v[DW-1:0];
    else if (shifted < min_v) sat_v = min_v[DW-1:0];
    else                      sat_v = shifted[DW-1:0];
    one_q = (DW+2)'(1) <<< FRAC_WIDTH;
    hs    = (DW+2)'(sat_v >>> 2) + (one_q >>> 1);
    act_v = sat_v;
    case (ACT_MODE)
      1: if (sat_v < 0) act_v = '0;
      2: begin
        if (hs < 0)          act_v = '0;
        else if (hs > one_q) act_v = one_q[DW-1:0];
        else                 act_v = hs[DW-1:0];
      end
      default: act_v = sat_v;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run      <= 1'b0;
      waddr    <= '0;
      bias_q   <= '0;
      bcnt     <= '0;
      dcnt     <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      acc      <= '0;
      out_data <= '0;
      sat_flag <= 1'b0;
    end else begin
      run <= 1'b1;
      if (w_we)
        waddr <= (waddr == AW'(NUM_WEIGHT - 1)) ? '0 : waddr + AW'(1);
      if (b_we) bias_q <= bias_value;
      if (beat_fire) bcnt <= last_beat ? '0 : bcnt + BW'(1);
      dcnt <= (state == DRAIN) ? dcnt + 2'd1 : 2'd0;
      v1 <= beat_fire;
      v2 <= v1;
      if (v2)
        acc <= acc + psum;
      else if (state == BIAS)
        acc <= acc + (ACC_W'(bias_q) <<< FRAC_WIDTH);
      else if (state == OUT && out_ready)
        acc <= '0;
      if (state == ACT) begin
        out_data <= act_v;
        sat_flag <= sat_flag | sat_hit;
      end
    end
  end

  // Weight RAM and datapath registers keep contents through reset
  always_ff @(posedge clk) begin
    if (w_we) mem[waddr] <= weight_value;
    for (int l = 0; l < LANES; l++) begin
      if (beat_fire) begin
        w_q[l] <= lane_ok[l] ? mem[lane_idx[l]] : '0;
        x_q[l] <= in_data[l*DW +: DW];
      end
      prod_q[l] <= x_q[l] * w_q[l];
    end
  end

endmodule

// File: tb/tb_neuron_mac_lanes.sv
// Bench for neuron_mac_lanes: directed table, corner sequences
// and randomized vectors against an arithmetic reference model.
module tb_neuron_mac_lanes;

  localparam int NW = 10;
  localparam int NX = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        cfg_layer_num, cfg_neuron_num;
  logic              weight_valid, bias_valid, in_valid, out_ready;
  logic [15:0]       weight_value, bias_value;
  logic [63:0]       in_data;
  logic [2:0]        in_ready, out_valid, busy, sat_flag;
  logic [2:0][15:0]  out_data;

  int n_cmp = 0;
  int n_err = 0;
  bit sticky = 1'b0;

  logic [15:0] cur_w [NW];
  logic [15:0] cur_x [NX];
  logic [15:0] cur_b;

  typedef struct {
    logic [15:0] w, x, b, e_id, e_relu, e_hs;
    bit          e_sat;
  } vec_t;
  vec_t tbl [7];

  always #5 clk = ~clk;

  neuron_mac_lanes #(.NUM_WEIGHT(NW), .ACT_MODE(0)) u_id (
    .clk(clk), .rst(rst),
    .cfg_layer_num(cfg_layer_num), .cfg_neuron_num(cfg_neuron_num),
    .weight_valid(weight_valid), .weight_value(weight_value),
    .bias_valid(bias_valid), .bias_value(bias_value),
    .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
    .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_data(out_data[0]), .busy(busy[0]), .sat_flag(sat_flag[0]));

  neuron_mac_lanes #(.NUM_WEIGHT(NW), .ACT_MODE(1)) u_relu (
    .clk(clk), .rst(rst),
    .cfg_layer_num(cfg_layer_num), .cfg_neuron_num(cfg_neuron_num),
    .weight_valid(weight_valid), .weight_value(weight_value),
    .bias_valid(bias_valid), .bias_value(bias_value),
    .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
    .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_data(out_data[1]), .busy(busy[1]), .sat_flag(sat_flag[1]));

  neuron_mac_lanes #(.NUM_WEIGHT(NW), .ACT_MODE(2)) u_hs (
    .clk(clk), .rst(rst),
    .cfg_layer_num(cfg_layer_num), .cfg_neuron_num(cfg_neuron_num),
    .weight_valid(weight_valid), .weight_value(weight_value),
    .bias_valid(bias_valid), .bias_value(bias_value),
    .in_valid(in_valid), .in_ready(in_ready[2]), .in_data(in_data),
    .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_data(out_data[2]), .busy(busy[2]), .sat_flag(sat_flag[2]));

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic void model(output logic [15:0] e_id,
                                output logic [15:0] e_relu,
                                output logic [15:0] e_hs,
                                output bit e_sat);
    longint s, c, h;
    s = 0;
    for (int i = 0; i < NW; i++)
      s += longint'($signed(cur_w[i])) * longint'($signed(cur_x[i]));
    s += longint'($signed(cur_b)) * 256;
    c = s >>> 8;
    e_sat = (c > 32767) || (c < -32768);
    if (c > 32767)  c = 32767;
    if (c < -32768) c = -32768;
    e_id   = 16'(c);
    e_relu = (c < 0) ? 16'd0 : 16'(c);
    h = (c >>> 2) + 128;
    if (h < 0)   h = 0;
    if (h > 256) h = 256;
    e_hs = 16'(h);
  endfunction

  function automatic logic [15:0] rnd(input int scale);
    case (scale)
      0:       return 16'($urandom_range(0, 1023)) - 16'd512;
      1:       return 16'($urandom);
      default: return 16'($urandom_range(0, 8191)) - 16'd4096;
    endcase
  endfunction

  task automatic set_row(input vec_t r);
    for (int i = 0; i < NW; i++) begin
      cur_w[i] = r.w;
      cur_x[i] = r.x;
    end
    cur_x[10] = 16'h7FFF;
    cur_x[11] = 16'h8001;
    cur_b = r.b;
  endtask

  task automatic load_w();
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      weight_valid = 1'b1;
      weight_value = cur_w[i];
    end
    @(negedge clk);
    weight_valid = 1'b0;
    bias_valid   = 1'b1;
    bias_value   = cur_b;
    @(negedge clk);
    bias_valid = 1'b0;
  endtask

  task automatic drive_beats(input int nb, input bit wjunk);
    for (int b = 0; b < nb; b++) begin
      int t;
      in_valid = 1'b1;
      for (int l = 0; l < 4; l++)
        in_data[l*16 +: 16] = cur_x[b*4+l];
      if (wjunk && b > 0) begin
        weight_valid = 1'b1;
        weight_value = 16'h5A5A;
      end
      #1;
      t = 0;
      while (!in_ready[0] && t < 20) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (t >= 20) chk("in_ready timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid     = 1'b0;
    weight_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 1;
    while (!out_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'd6);
  endtask

  task automatic check_out(input string tag, input logic [15:0] e_id,
                           input logic [15:0] e_relu,
                           input logic [15:0] e_hs, input bit e_sat);
    sticky |= e_sat;
    chk({tag, " out_valid"}, out_valid, 3'b111);
    chk({tag, " id"},   out_data[0], e_id);
    chk({tag, " relu"}, out_data[1], e_relu);
    chk({tag, " hsig"}, out_data[2], e_hs);
    chk({tag, " sat"},  sat_flag, {3{sticky}});
    chk({tag, " in_ready"}, in_ready, 3'b000);
    chk({tag, " busy"}, busy, 3'b111);
  endtask

  task automatic finish_out(input string tag);
    @(negedge clk);
    chk({tag, " idle busy"}, busy, 3'b000);
    chk({tag, " idle out_valid"}, out_valid, 3'b000);
  endtask

  task automatic run_vec(input string tag, input bit load,
                         input logic [15:0] e_id, input logic [15:0] e_relu,
                         input logic [15:0] e_hs, input bit e_sat);
    if (load) load_w();
    drive_beats(3, 1'b0);
    wait_out(tag);
    check_out(tag, e_id, e_relu, e_hs, e_sat);
    finish_out(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] m_id, m_relu, m_hs;
    bit          m_sat;
    bit          saw;

    tbl[0] = '{16'h0100, 16'h0100, 16'h0080, 16'h0A80, 16'h0A80, 16'h0100, 1'b0};
    tbl[1] = '{16'h0100, 16'hFF00, 16'h0000, 16'hF600, 16'h0000, 16'h0000, 1'b0};
    tbl[2] = '{16'h0010, 16'h0100, 16'hFF00, 16'hFFA0, 16'h0000, 16'h0068, 1'b0};
    tbl[3] = '{16'h0080, 16'h0100, 16'hFF00, 16'h0400, 16'h0400, 16'h0100, 1'b0};
    tbl[4] = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 1'b0};
    tbl[5] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h0100, 1'b1};
    tbl[6] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 1'b1};

    cfg_layer_num  = 8'd1;
    cfg_neuron_num = 8'd1;
    weight_valid   = 1'b0;
    weight_value   = '0;
    bias_valid     = 1'b0;
    bias_value     = '0;
    in_valid       = 1'b0;
    in_data        = '0;
    out_ready      = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst in_ready", in_ready, 3'b000);
    chk("rst out_valid", out_valid, 3'b000);
    chk("rst busy", busy, 3'b000);
    chk("rst sat", sat_flag, 3'b000);
    chk("rst out_data", out_data, 48'h0);
    rst = 1'b1;
    #1;
    chk("pre-edge in_ready", in_ready, 3'b000);
    @(negedge clk);
    chk("post-edge in_ready", in_ready, 3'b111);

    for (int i = 0; i < 7; i++) begin
      set_row(tbl[i]);
      run_vec($sformatf("row%0d", i), 1'b1, tbl[i].e_id,
              tbl[i].e_relu, tbl[i].e_hs, tbl[i].e_sat);
    end

    set_row(tbl[0]);
    load_w();
    out_ready = 1'b0;
    drive_beats(3, 1'b0);
    wait_out("hold");
    check_out("hold", 16'h0A80, 16'h0A80, 16'h0100, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold out_valid", out_valid, 3'b111);
      chk("hold out_data", out_data[0], 16'h0A80);
      chk("hold in_ready", in_ready, 3'b000);
    end
    out_ready = 1'b1;
    finish_out("hold");
    run_vec("after hold", 1'b0, 16'h0A80, 16'h0A80, 16'h0100, 1'b0);

    for (int k = 0; k < 2 * NW; k++) begin
      @(negedge clk);
      cfg_neuron_num = (k < NW) ? 8'd2 : 8'd1;
      cfg_layer_num  = (k < NW) ? 8'd1 : 8'd3;
      weight_valid   = 1'b1;
      weight_value   = 16'h5555;
      bias_valid     = 1'b1;
      bias_value     = 16'h7777;
    end
    @(negedge clk);
    weight_valid   = 1'b0;
    bias_valid     = 1'b0;
    cfg_layer_num  = 8'd1;
    cfg_neuron_num = 8'd1;
    bias_valid     = 1'b1;
    bias_value     = 16'h0080;
    in_valid       = 1'b1;
    #1;
    chk("cfg priority in_ready", in_ready, 3'b000);
    @(negedge clk);
    bias_valid = 1'b0;
    drive_beats(3, 1'b1);
    wait_out("ignored writes");
    check_out("ignored writes", 16'h0A80, 16'h0A80, 16'h0100, 1'b0);
    finish_out("ignored writes");

    drive_beats(2, 1'b0);
    rst = 1'b0;
    #1;
    sticky = 1'b0;
    chk("mid rst in_ready", in_ready, 3'b000);
    chk("mid rst out_valid", out_valid, 3'b000);
    chk("mid rst busy", busy, 3'b000);
    chk("mid rst sat", sat_flag, 3'b000);
    chk("mid rst out_data", out_data, 48'h0);
    @(negedge clk);
    rst = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid != 3'b000) saw = 1'b1;
    end
    chk("no out after rst", 64'(saw), 64'd0);
    bias_valid = 1'b1;
    bias_value = cur_b;
    @(negedge clk);
    bias_valid = 1'b0;
    run_vec("after rst", 1'b0, 16'h0A80, 16'h0A80, 16'h0100, 1'b0);

    for (int v = 0; v < 12; v++) begin
      int sw, sx;
      sw = $urandom_range(0, 2);
      sx = $urandom_range(0, 2);
      for (int i = 0; i < NW; i++) cur_w[i] = rnd(sw);
      for (int i = 0; i < NX; i++) cur_x[i] = rnd(sx);
      cur_b = rnd($urandom_range(0, 2));
      model(m_id, m_relu, m_hs, m_sat);
      run_vec($sformatf("rand%0d", v), 1'b1, m_id, m_relu, m_hs, m_sat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/neuron_mac_lanes.md
NEURON_MAC_LANES -- requirements
Module: neuron_mac_lanes

Interface
REQ-001 SHALL have parameter LAYER_NO, default 1, layer ID matched against cfg_layer_num.
REQ-002 SHALL have parameter NEURON_NO, default 1, neuron ID matched against cfg_neuron_num.
REQ-003 SHALL have parameter NUM_WEIGHT, default 128, number of weights (at least 1).
REQ-004 SHALL have parameter DATA_WIDTH, default 16, signed fixed-point word width.
REQ-005 SHALL have parameter FRAC_WIDTH, default 8, fractional bits of every word.
REQ-006 SHALL have parameter LANES, default 4, inputs consumed per beat (1..16).
REQ-007 SHALL have parameter ACT_MODE, default 0; 0=identity, 1=relu, 2=hard-sigmoid.
REQ-008 SHALL have port clk, input, 1 bit, sole clock.
REQ-009 SHALL have port rst, input, 1 bit; reset is asynchronous and active-low.
REQ-010 SHALL have port cfg_layer_num, input, 8 bits, load target layer.
REQ-011 SHALL have port cfg_neuron_num, input, 8 bits, load target neuron.
REQ-012 SHALL have port weight_valid, input, 1 bit, plus weight_value, input, DATA_WIDTH bits.
REQ-013 SHALL have port bias_valid, input, 1 bit, plus bias_value, input, DATA_WIDTH bits.
REQ-014 SHALL have ports in_valid (input, 1 bit), in_ready (output, 1 bit) and in_data (input, LANES*DATA_WIDTH bits); lane l is in_data[l*DATA_WIDTH +: DATA_WIDTH].
REQ-015 SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit) and out_data (output, DATA_WIDTH bits).
REQ-016 SHALL have ports busy (output, 1 bit) and sat_flag (output, 1 bit, sticky).

Function
REQ-017 SHALL store weights in an internal NUM_WEIGHT-entry RAM with a synchronous read.
REQ-018 SHALL write a weight, at the next address, only when weight_valid is high, the config IDs match, and the state is IDLE.
REQ-019 SHALL wrap the write address from NUM_WEIGHT-1 to 0.
REQ-020 SHALL, on an accepted bias_valid, latch bias_value, under the same ID match and IDLE condition as weights.
REQ-021 SHALL implement FSM states IDLE, ACCUM, DRAIN, BIAS, ACT and OUT.
REQ-022 SHALL transition IDLE->ACCUM on the first accepted input beat.
REQ-023 SHALL transition ACCUM->DRAIN on acceptance of beat BEATS-1, where BEATS=ceil(NUM_WEIGHT/LANES).
REQ-024 SHALL stay in DRAIN 3 cycles, then go DRAIN->BIAS->ACT->OUT at one cycle each.
REQ-025 SHALL transition OUT->IDLE on out_valid && out_ready.
REQ-026 SHALL drive in_ready high only in IDLE and ACCUM; a beat is accepted when in_valid && in_ready.
REQ-027 SHALL multiply lane l of beat b by weight index b*LANES+l, signed, into 2*DATA_WIDTH-bit products.
REQ-028 SHALL treat lanes whose index is NUM_WEIGHT or above as zero (last-beat mask).
REQ-029 SHALL accumulate in ACC_W = 2*DATA_WIDTH+clog2(NUM_WEIGHT)+1 signed bits, with no internal overflow.
REQ-030 SHALL, in BIAS, add sign-extended bias <<< FRAC_WIDTH to the accumulator.
REQ-031 SHALL, in ACT, arithmetic-shift the sum right by FRAC_WIDTH and saturate it to the signed DATA_WIDTH range.
REQ-032 SHALL set sat_flag on saturation; sat_flag clears only on reset.
REQ-033 SHALL, for relu, output 0 for negative values.
REQ-034 SHALL, for hard-sigmoid, compute y=clamp((x>>>2)+0.5, 0, 1.0) in Q(FRAC_WIDTH).
REQ-035 SHALL assert out_valid exactly 6 cycles after the last beat is accepted.
REQ-036 SHALL hold out_data stable while out_valid && !out_ready.
REQ-037 SHALL clear the accumulator on OUT->IDLE.
REQ-038 SHALL drive busy high in every state except IDLE.
REQ-039 SHALL give priority to weight and bias writes over a same-cycle in_valid in IDLE; in_ready is low that cycle.

Reset
REQ-040 SHALL, while rst is low, immediately force IDLE, in_ready=0, out_valid=0, out_data=0, busy=0, sat_flag=0, accumulator=0, write address=0 and bias=0.
REQ-041 SHALL keep weight RAM contents through reset.
REQ-042 SHALL, after rst deasserts, raise in_ready on the first clk edge.
REQ-043 SHALL, on reset mid-operation, discard the partial sum, with no out_valid produced.

Verification (DATA_WIDTH=16, FRAC_WIDTH=8, LANES=4, NUM_WEIGHT=10, ACT_MODE=0 unless stated)
REQ-044 SHALL cover: 10 weights 0x0100, bias 0x0080, 3 beats all 0x0100 -> out_data=0x0A80, 6 cycles after beat 3, sat_flag=0.
REQ-045 SHALL cover: ACT_MODE=1, weights 0x0100, inputs 0xFF00, bias 0 -> out_data=0x0000.
REQ-046 SHALL cover: weights 0x7FFF, inputs 0x7FFF -> out_data=0x7FFF, sat_flag=1 and staying 1 afterwards.
REQ-047 SHALL cover: out_ready low for 4 cycles -> out_valid and out_data held, in_ready=0; the next vector is accepted after the handshake.
REQ-048 SHALL cover: weight_valid with cfg_neuron_num!=NEURON_NO, or during ACCUM -> RAM unchanged, and the result is identical to REQ-044.
REQ-049 SHALL cover: rst low after beat 2 -> no out_valid, and a fresh 3-beat vector then gives 0x0A80.
